// File: rtl/sram_stream_addr_gen.sv
// sram_stream_addr_gen: circular-buffer SRAM address generator that delays a pixel stream by LAG words
module sram_stream_addr_gen #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256,
    parameter int LAG    = 64,
    parameter int FRAME  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              wen_in,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              ren_in,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              done
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(FRAME + 1);
    localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
    localparam logic [OW-1:0] LAG_C   = OW'(LAG);
    localparam logic [CW-1:0] FRAME_C = CW'(FRAME);

    typedef enum logic [2:0] {IDLE, FILL, STREAM, DRAIN, DONE} state_t;

    state_t            r_state, w_state_n;
    logic [PW-1:0]     r_wptr, r_rptr, w_wptr_n, w_rptr_n;
    logic [OW-1:0]     r_occ, w_occ_n;
    logic [CW-1:0]     r_wcnt, r_rcnt, w_wcnt_n, w_rcnt_n;
    logic              r_rd_pend, r_skid_v;
    logic [DATA_W-1:0] r_skid_d;
    logic              w_live, w_ov, w_free, w_clr;

    // Nothing is commanded while in reset or flushing.
    assign w_live   = ~rst & ~flush;
    assign in_ready = w_live && r_occ < DEPTH_C && r_state != DONE && r_wcnt < FRAME_C;
    assign wen_in   = in_valid & in_ready;
    assign waddr    = ADDR_W'(r_wptr);
    assign wdata    = rst ? '0 : in_data;

    // A word is presented straight from rdata the cycle after its read, then parked in the skid if stalled.
    assign w_ov      = r_rd_pend | r_skid_v;
    assign out_valid = w_ov & ~flush;
    assign out_data  = r_skid_v ? r_skid_d : (r_rd_pend ? rdata : '0);
    assign w_free    = ~r_skid_v & (~w_ov | out_ready);
    assign ren_in    = w_live && (r_state == STREAM || r_state == DRAIN) && r_occ != '0 && r_rcnt < FRAME_C && w_free;
    assign raddr     = ADDR_W'(r_rptr);
    assign done      = out_valid && out_ready && r_state == DRAIN && r_rcnt == FRAME_C;
    assign w_clr     = flush | (r_state == DONE);

    // Next pointers, counts and FSM state.
    always_comb begin
        w_wptr_n  = !wen_in ? r_wptr : (r_wptr == PTR_MAX ? '0 : r_wptr + PW'(1));
        w_rptr_n  = !ren_in ? r_rptr : (r_rptr == PTR_MAX ? '0 : r_rptr + PW'(1));
        w_occ_n   = r_occ + OW'(wen_in) - OW'(ren_in);
        w_wcnt_n  = r_wcnt + CW'(wen_in);
        w_rcnt_n  = r_rcnt + CW'(ren_in);
        w_state_n = r_state;
        case (r_state)
            IDLE:    w_state_n = wen_in ? FILL : IDLE;
            FILL:    w_state_n = (w_wcnt_n == FRAME_C) ? DRAIN : (w_occ_n >= LAG_C ? STREAM : FILL);
            STREAM:  w_state_n = (w_wcnt_n == FRAME_C) ? DRAIN : STREAM;
            DRAIN:   w_state_n = done ? DONE : DRAIN;
            default: w_state_n = IDLE;
        endcase
    end

    // Frame bookkeeping; flush or the DONE state restarts everything from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_occ   <= '0;
            r_wcnt  <= '0;
            r_rcnt  <= '0;
        end else begin
            r_state <= w_clr ? IDLE : w_state_n;
            r_wptr  <= w_clr ? '0 : w_wptr_n;
            r_rptr  <= w_clr ? '0 : w_rptr_n;
            r_occ   <= w_clr ? '0 : w_occ_n;
            r_wcnt  <= w_clr ? '0 : w_wcnt_n;
            r_rcnt  <= w_clr ? '0 : w_rcnt_n;
        end
    end

    // Output stage: track the in-flight read and catch it in the skid when downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend <= 1'b0;
            r_skid_v  <= 1'b0;
            r_skid_d  <= '0;
        end else if (flush) begin
            r_rd_pend <= 1'b0;
            r_skid_v  <= 1'b0;
            r_skid_d  <= '0;
        end else begin
            r_rd_pend <= ren_in;
            r_skid_v  <= w_ov & ~out_ready;
            if (r_rd_pend && !out_ready) r_skid_d <= rdata;
        end
    end
endmodule

// File: tb/tb_sram_stream_addr_gen.sv
// tb_sram_stream_addr_gen: directed stimulus with a frame-level reference model for sram_stream_addr_gen
module tb_sram_stream_addr_gen;
    localparam int DEPTH = 8;
    localparam int LAG   = 4;
    localparam int FRAME = 20;

    logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [15:0] in_data = 0;
    logic        in_ready, wen_in, ren_in, out_valid, done;
    logic [15:0] waddr, raddr, wdata, out_data;
    logic [15:0] rdata = 0;
    logic        b_in_ready, b_wen, b_ren, b_ov, b_done;
    logic [15:0] b_waddr, b_raddr, b_wdata, b_odata;
    logic [15:0] b_rdata = 0;
    logic [15:0] mem [DEPTH];
    logic [15:0] mem_b [DEPTH];
    int          checks = 0, errors = 0;
    int          nw, dcnt, bdcnt;

    always #5 clk = ~clk;

    sram_stream_addr_gen #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .LAG(LAG), .FRAME(FRAME)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wen_in(wen_in), .waddr(waddr), .wdata(wdata), .ren_in(ren_in), .raddr(raddr), .rdata(rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .done(done)
    );

    sram_stream_addr_gen #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .LAG(4), .FRAME(3)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .wen_in(b_wen), .waddr(b_waddr), .wdata(b_wdata), .ren_in(b_ren), .raddr(b_raddr), .rdata(b_rdata),
        .out_valid(b_ov), .out_ready(out_ready), .out_data(b_odata), .done(b_done)
    );

    // SRAMs: synchronous write, read data valid the cycle after the read command
    always @(posedge clk) begin
        if (wen_in) mem[waddr[2:0]] <= wdata;
        if (ren_in) rdata <= mem[raddr[2:0]];
        if (b_wen) mem_b[b_waddr[2:0]] <= b_wdata;
        if (b_ren) b_rdata <= mem_b[b_raddr[2:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [15:0] d, input logic r, input logic f, input logic rs);
        @(posedge clk);
        #1;
        rst = rs;
        in_valid = v;
        in_data = d;
        out_ready = r;
        flush = f;
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [15:0] base, input string tag);
        bit fin = 0;
        for (int j = 0; j < 300 && !fin; j++) begin
            cyc(nw < FRAME, base + 16'(nw), 1, 0, 0);
            if (wen_in) nw++;
            fin = done;
        end
        chk({tag, "_done"}, 32'(fin), 1);
        chk({tag, "_writes"}, nw, FRAME);
    endtask

    // Reference model: words leave in arrival order, addresses are arrival/read index mod DEPTH.
    int          m_wr, m_rd, m_acc;
    bit          m_post, m_go, m_stall;
    logic [15:0] m_last;
    logic [15:0] m_px [FRAME];
    always @(negedge clk) begin
        if (rst || flush) begin
            if (!rst) begin
                chk("flush_out_valid", out_valid, 0);
                chk("flush_wen", wen_in, 0);
                chk("flush_ren", ren_in, 0);
                chk("flush_in_ready", in_ready, 0);
            end
            m_wr = 0; m_rd = 0; m_acc = 0; m_post = 0; m_go = 0; m_stall = 0;
        end else begin
            chk("m_in_ready", in_ready, !m_post && (m_wr - m_rd) < DEPTH && m_wr < FRAME);
            chk("m_wen", wen_in, in_valid && in_ready);
            if (m_stall) begin
                chk("m_hold_valid", out_valid, 1);
                chk("m_hold_data", out_data, m_last);
            end
            if (ren_in) begin
                chk("m_ren_legal", m_go && m_rd < m_wr && m_rd < FRAME, 1);
                chk("m_raddr", raddr, m_rd % DEPTH);
                m_rd++;
            end
            if (wen_in) begin
                chk("m_waddr", waddr, m_wr % DEPTH);
                chk("m_wdata", wdata, in_data);
                if (m_wr < FRAME) m_px[m_wr] = in_data;
                m_wr++;
            end
            if (out_valid && out_ready) begin
                chk("m_out_data", out_data, (m_acc < FRAME && m_acc < m_rd) ? m_px[m_acc] : 16'hDEAD);
                chk("m_done", done, m_acc == FRAME - 1);
                m_acc++;
            end else begin
                chk("m_done_idle", done, 0);
            end
            m_stall = out_valid && !out_ready;
            m_last = out_data;
            if (m_wr - m_rd >= LAG || m_wr == FRAME) m_go = 1;
            if (m_post) begin
                m_wr = 0; m_rd = 0; m_acc = 0; m_post = 0; m_go = 0; m_stall = 0;
            end else if (done) begin
                m_post = 1;
            end
        end
    end

    initial begin
        in_valid = 1;
        in_data = 16'hBEEF;
        out_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wen", wen_in, 0);
        chk("rst_ren", ren_in, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_done", done, 0);
        chk("rst_b_in_ready", b_in_ready, 0);

        // fill, wrap and done with continuous input; short frame on dut_b
        dcnt = 0;
        bdcnt = 0;
        for (int k = 0; k < 28; k++) begin
            cyc(k < 20, 16'hA000 + 16'(k), 1, 0, 0);
            if (k == 0) chk("first_write_after_rst", wen_in, 1);
            if (k < 4) begin
                chk("fill_waddr", waddr, k);
                chk("fill_no_ren", ren_in, 0);
            end
            if (k == 4) begin
                chk("first_ren", ren_in, 1);
                chk("first_raddr", raddr, 0);
            end
            if (k == 5) begin
                chk("first_out_valid", out_valid, 1);
                chk("first_out_data", out_data, 16'hA000);
            end
            if (k == 8) chk("wrap_waddr", waddr, 0);
            if (k == 12) chk("wrap_raddr", raddr, 0);
            if (k == 24) chk("done_last", done, 1);
            if (k == 3) begin
                chk("short_ren", b_ren, 1);
                chk("short_raddr", b_raddr, 0);
                chk("short_in_ready", b_in_ready, 0);
            end
            if (k == 4) chk("short_out0", b_odata, 16'hA000);
            if (k == 5) chk("short_no_done", b_done, 0);
            if (k == 6) begin
                chk("short_done", b_done, 1);
                chk("short_out2", b_odata, 16'hA002);
            end
            if (done) dcnt++;
            if (k < 8 && b_done) bdcnt++;
        end
        chk("done_once", dcnt, 1);
        chk("short_done_once", bdcnt, 1);

        // full buffer with downstream stalled, then release
        nw = 0;
        for (int j = 0; j < 12; j++) begin
            cyc(1, 16'hB000 + 16'(nw), 0, 0, 0);
            if (j == 8) chk("full_last_waddr", waddr, 0);
            if (j == 9) chk("full_ready_low", in_ready, 0);
            if (j >= 10) chk("full_no_wen", wen_in, 0);
            if (wen_in) nw++;
        end
        chk("full_writes", nw, 9);
        run_frame(16'hB000, "full");

        // backpressure pattern 1,0,0,1
        cyc(0, 0, 1, 0, 0);
        nw = 0;
        begin
            bit fin = 0;
            for (int j = 0; j < 300 && !fin; j++) begin
                cyc(nw < FRAME, 16'hC000 + 16'(nw), (j % 4 == 0) || (j % 4 == 3), 0, 0);
                if (j == 6) begin
                    chk("bp_hold_valid", out_valid, 1);
                    chk("bp_hold_data", out_data, 16'hC000);
                end
                if (j == 7) begin
                    chk("bp_skid_out", out_data, 16'hC000);
                    chk("bp_no_ren", ren_in, 0);
                end
                if (j == 8) begin
                    chk("bp_ren", ren_in, 1);
                    chk("bp_raddr", raddr, 1);
                end
                if (j == 9) chk("bp_next", out_data, 16'hC001);
                if (wen_in) nw++;
                fin = done;
            end
            chk("bp_done", 32'(fin), 1);
        end

        // flush mid-stream at occupancy 5
        cyc(0, 0, 1, 0, 0);
        nw = 0;
        for (int j = 0; j < 6; j++) begin
            cyc(1, 16'hD000 + 16'(nw), 0, 0, 0);
            if (wen_in) nw++;
        end
        cyc(1, 16'hD0FF, 0, 1, 0);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 0);
        cyc(1, 16'hE000, 1, 0, 0);
        chk("fl_after_valid", out_valid, 0);
        chk("fl_after_wen", wen_in, 1);
        chk("fl_after_waddr", waddr, 0);
        nw = 1;
        run_frame(16'hE000, "fl");

        // reset mid-stream at occupancy 5
        cyc(0, 0, 1, 0, 0);
        nw = 0;
        for (int j = 0; j < 6; j++) begin
            cyc(1, 16'hF000 + 16'(nw), 0, 0, 0);
            if (wen_in) nw++;
        end
        cyc(1, 16'hF0FF, 0, 0, 1);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready", in_ready, 0);
        chk("mrst_wen", wen_in, 0);
        chk("mrst_ren", ren_in, 0);
        chk("mrst_waddr", waddr, 0);
        chk("mrst_wdata", wdata, 0);
        cyc(1, 16'h1000, 1, 0, 0);
        chk("mrst_after_valid", out_valid, 0);
        chk("mrst_after_wen", wen_in, 1);
        chk("mrst_after_waddr", waddr, 0);
        nw = 1;
        run_frame(16'h1000, "mrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
